inst_fetch_queue: RTL and testbench

- Parametrised instruction buffer between fetch and instDecoder. Holds (instruction, PC) pairs in a first-word-fall-through FIFO.
- Pre-decodes each entry's opcode class when it is written, so downstream issue logic sees the class without waiting for full decode.
- Decouples fetch from decode stalls through valid/ready handshakes on both sides.
- Honours pipeline flush.

---
 rtl/inst_fetch_queue.sv | 137 +++++++++++++
 tb/tb_inst_fetch_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   First-word-fall-through instruction buffer between fetch and decode.
//   Each entry holds (instruction, PC) plus an opcode class computed at write time.
//
// Ports
//   iClk, iRst                clock (rising edge), asynchronous active-low reset
//   iInst, iPC, iValid        write side from fetch
//   oReady                    queue can accept a write (not full)
//   iFlushPipe                synchronous flush, discards every entry
//   oInst, oPC, oOpClass      head entry (zero when empty); class is one-hot
//                             {illegal, reg, mem, branch}
//   oValid, iReady            read side to decode
//   oCount, oFull, oEmpty     occupancy status
module inst_fetch_queue #(
    parameter int unsigned cXLEN = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNTW = $clog2(DEPTH) + 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [cXLEN-1:0] iInst,
    input  logic [cXLEN-1:0] iPC,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iFlushPipe,
    output logic [cXLEN-1:0] oInst,
    output logic [cXLEN-1:0] oPC,
    output logic [3:0]       oOpClass,
    output logic             oValid,
    input  logic             iReady,
    output logic [CNTW-1:0]  oCount,
    output logic             oFull,
    output logic             oEmpty
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    // One-hot class encoding: bit 3 illegal, bit 2 reg, bit 1 mem, bit 0 branch.
    function automatic logic [3:0] predecode(input logic [6:0] opcode);
        logic [3:0] cls;
        if (opcode[1:0] != 2'b11) begin
            cls = 4'b1000;
        end else begin
            case (opcode)
                7'b1100011, 7'b1101111, 7'b1100111:             cls = 4'b0001;
                7'b0000011, 7'b0100011:                         cls = 4'b0010;
                7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: cls = 4'b0100;
                default:                                        cls = 4'b1000;
            endcase
        end
        return cls;
    endfunction

    logic [cXLEN-1:0] inst_mem [DEPTH];
    logic [cXLEN-1:0] pc_mem   [DEPTH];
    logic [3:0]       cls_mem  [DEPTH];

    logic [PTRW-1:0] wptr_q, wptr_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Flush overrides both handshakes; readiness depends only on the current count,
    // so a same-cycle pop never makes room for a push.
    assign push = iValid && !full && !iFlushPipe;
    assign pop  = !empty && iReady && !iFlushPipe;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (iFlushPipe) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge iClk) begin
        if (push) begin
            inst_mem[wptr_q] <= iInst;
            pc_mem[wptr_q]   <= iPC;
            cls_mem[wptr_q]  <= predecode(iInst[6:0]);
        end
    end

    always_comb begin
        oInst    = '0;
        oPC      = '0;
        oOpClass = '0;
        if (!empty) begin
            oInst    = inst_mem[rptr_q];
            oPC      = pc_mem[rptr_q];
            oOpClass = cls_mem[rptr_q];
        end
    end

    assign oValid = !empty;
    assign oReady = !full;
    assign oFull  = full;
    assign oEmpty = empty;
    assign oCount = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic [31:0] iInst = '0;
    logic [31:0] iPC = '0;
    logic        iValid = 1'b0;
    logic        oReady;
    logic        iFlushPipe = 1'b0;
    logic [31:0] oInst;
    logic [31:0] oPC;
    logic [3:0]  oOpClass;
    logic        oValid;
    logic        iReady = 1'b0;
    logic [2:0]  oCount;
    logic        oFull;
    logic        oEmpty;

    inst_fetch_queue #(.cXLEN(32), .DEPTH(DEPTH)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iInst     (iInst),
        .iPC       (iPC),
        .iValid    (iValid),
        .oReady    (oReady),
        .iFlushPipe(iFlushPipe),
        .oInst     (oInst),
        .oPC       (oPC),
        .oOpClass  (oOpClass),
        .oValid    (oValid),
        .iReady    (iReady),
        .oCount    (oCount),
        .oFull     (oFull),
        .oEmpty    (oEmpty)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        v;
        logic        r;
        logic        f;
        logic [3:0]  cls;  // expected class of inst if it gets stored
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [3:0]  cls;
    } ent_t;

    ent_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check pre-edge outputs against the scoreboard,
    // update the scoreboard, then advance past the rising edge.
    task automatic step(input string tag, input vec_t vc);
        int  sz;
        bit  do_push;
        bit  do_pop;
        ent_t e;
        iInst      = vc.inst;
        iPC        = vc.pc;
        iValid     = vc.v;
        iReady     = vc.r;
        iFlushPipe = vc.f;
        #1;
        sz = sb.size();
        chk({tag, ".count"}, 64'(oCount), 64'(sz));
        chk({tag, ".valid"}, 64'(oValid), 64'(sz != 0));
        chk({tag, ".ready"}, 64'(oReady), 64'(sz < DEPTH));
        chk({tag, ".full"},  64'(oFull),  64'(sz == DEPTH));
        chk({tag, ".empty"}, 64'(oEmpty), 64'(sz == 0));
        if (sz != 0) begin
            chk({tag, ".inst"}, 64'(oInst),    64'(sb[0].inst));
            chk({tag, ".pc"},   64'(oPC),      64'(sb[0].pc));
            chk({tag, ".cls"},  64'(oOpClass), 64'(sb[0].cls));
        end else begin
            chk({tag, ".inst0"}, 64'(oInst),    64'h0);
            chk({tag, ".pc0"},   64'(oPC),      64'h0);
            chk({tag, ".cls0"},  64'(oOpClass), 64'h0);
        end
        do_pop  = (sz != 0) && vc.r && !vc.f;
        do_push = vc.v && (sz < DEPTH) && !vc.f;
        if (vc.f) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                e.inst = vc.inst;
                e.pc   = vc.pc;
                e.cls  = vc.cls;
                sb.push_back(e);
            end
        end
        @(posedge iClk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                input logic v, input logic r, input logic f,
                                input logic [3:0] cls);
        vec_t t;
        t.inst = inst; t.pc = pc; t.v = v; t.r = r; t.f = f; t.cls = cls;
        return t;
    endfunction

    initial begin
        // Reset state while held in reset.
        repeat (2) @(posedge iClk);
        #1;
        chk("rst.empty", 64'(oEmpty), 64'h1);
        chk("rst.ready", 64'(oReady), 64'h1);
        chk("rst.valid", 64'(oValid), 64'h0);
        chk("rst.count", 64'(oCount), 64'h0);
        chk("rst.cls",   64'(oOpClass), 64'h0);
        chk("rst.full",  64'(oFull), 64'h0);
        #3 iRst = 1'b1;
        @(posedge iClk);
        #1;

        // Fill, refuse when full, pop-only while full, drain, idle pop on empty.
        tbl.push_back(mk(32'h0000_0013, 32'h0, 1, 0, 0, 4'b0100));
        tbl.push_back(mk(32'h0000_2003, 32'h4, 1, 0, 0, 4'b0010));
        tbl.push_back(mk(32'h0000_0063, 32'h8, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(32'h0000_006F, 32'hC, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(32'h0000_0033, 32'h10, 1, 0, 0, 4'b0100));  // refused
        tbl.push_back(mk(32'h0000_0033, 32'h14, 1, 1, 0, 4'b0100));  // pop frees no slot
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));          // empty, no effect
        // Pre-decode coverage streamed through with simultaneous push/pop.
        tbl.push_back(mk(32'h0000_0000, 32'h20, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(32'h0000_007F, 32'h24, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(32'h0000_0012, 32'h28, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(32'h0000_0003, 32'h2C, 1, 1, 0, 4'b0010));
        tbl.push_back(mk(32'h0000_0023, 32'h30, 1, 1, 0, 4'b0010));
        tbl.push_back(mk(32'h0000_0067, 32'h34, 1, 1, 0, 4'b0001));
        tbl.push_back(mk(32'h0000_0037, 32'h38, 1, 1, 0, 4'b0100));
        tbl.push_back(mk(32'h0000_0017, 32'h3C, 1, 1, 0, 4'b0100));
        tbl.push_back(mk(32'h0000_0073, 32'h40, 1, 1, 0, 4'b1000));
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        tbl.push_back(mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

        // Steady stream: pointers wrap, occupancy settles at 1.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("strm%0d", i), mk(32'h0000_0013 | (32'(i) << 7),
                 32'h1000 + 32'(4 * i), 1, 1, 0, 4'b0100));
        end
        step("strm_end", mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));

        // Flush with three entries held and a write offered in the same cycle.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("pre_fl%0d", i), mk(32'h0000_2003, 32'h200 + 32'(4 * i),
                 1, 0, 0, 4'b0010));
        end
        step("flush", mk(32'h0000_0033, 32'h300, 1, 1, 1, 4'b0100));
        chk("flush.count_after", 64'(oCount), 64'h0);
        chk("flush.valid_after", 64'(oValid), 64'h0);
        step("post_fl_push", mk(32'h0000_0063, 32'h400, 1, 0, 0, 4'b0001));
        step("post_fl_head", mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        step("post_fl_idle", mk(32'h0, 32'h0, 0, 0, 0, 4'b0000));

        // Asynchronous reset between edges while holding two entries.
        step("ar0", mk(32'h0000_006F, 32'h500, 1, 0, 0, 4'b0001));
        step("ar1", mk(32'h0000_0013, 32'h504, 1, 0, 0, 4'b0100));
        iValid = 1'b0;
        chk("ar.count_before", 64'(oCount), 64'h2);
        #2 iRst = 1'b0;
        #1;
        chk("ar.valid", 64'(oValid), 64'h0);
        chk("ar.count", 64'(oCount), 64'h0);
        chk("ar.empty", 64'(oEmpty), 64'h1);
        chk("ar.inst",  64'(oInst),  64'h0);
        sb.delete();
        #1 iRst = 1'b1;
        @(posedge iClk);
        #1;
        step("ar_push", mk(32'h0000_0003, 32'h600, 1, 0, 0, 4'b0010));
        step("ar_head", mk(32'h0, 32'h0, 0, 1, 0, 4'b0000));
        step("ar_done", mk(32'h0, 32'h0, 0, 0, 0, 4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
